// File: rtl/seg7_scan_capture.sv
// Purpose: recovers the four digits shown on a multiplexed active-low 7-segment display by sampling its pins.
// Latency: pins held stable from sampling edge 1 are captured into DIGk at edge STABLE_CNT+2; decode is combinational.
// Backpressure: none; the display drives the pins freely and every clock takes one sample.
//
// Ports:
//   CLK, RST_N            clock (rising edge) and asynchronous active-low reset
//   SEG_IN[7:0]           segment pins, active-low, bit0=A .. bit6=G, bit7=DP
//   CS_N[3:0]             digit selects, active-low, bit k selects digit k
//   CLR_ERR               one-cycle pulse that clears CS_ERR
//   DIG0..DIG3[7:0]       last captured raw segment code per digit
//   DIG_VALID[3:0]        bit k set while DIGk is fresh (refresh timeout not yet expired)
//   HEX_NIB[15:0]         decoded nibble per digit, [4k+3:4k] = digit k
//   HEX_OK[3:0]           bit k set when DIGk[6:0] is a recognised hex glyph
//   FRAME_STB             one-cycle pulse when all four digits have been captured since the last pulse
//   CS_ERR                sticky flag, set when more than one select is low at once
module seg7_scan_capture #(
    parameter int STABLE_CNT = 8,
    parameter int TO_W       = 20
) (
    input  logic        RST_N,
    input  logic        CLK,
    input  logic [7:0]  SEG_IN,
    input  logic [3:0]  CS_N,
    input  logic        CLR_ERR,
    output logic [7:0]  DIG0,
    output logic [7:0]  DIG1,
    output logic [7:0]  DIG2,
    output logic [7:0]  DIG3,
    output logic [3:0]  DIG_VALID,
    output logic [15:0] HEX_NIB,
    output logic [3:0]  HEX_OK,
    output logic        FRAME_STB,
    output logic        CS_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // The sample that completes a capture arrives while the counter still reads STABLE_CNT-1.
    localparam logic [7:0]      CAP_AT   = 8'(STABLE_CNT - 1);
    localparam logic [TO_W-1:0] AGE_MAX  = '1;
    localparam logic [TO_W-1:0] AGE_ONE  = TO_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [7:0] seg_s1, seg_s2;
    logic [3:0] cs_s1, cs_s2;
    // Marks when seg_s2/cs_s2 hold a real pin sample rather than reset fill.
    logic [1:0] sync_fill;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_s1    <= 8'hFF;
            seg_s2    <= 8'hFF;
            cs_s1     <= 4'hF;
            cs_s2     <= 4'hF;
            sync_fill <= 2'b00;
        end else begin
            seg_s1    <= SEG_IN;
            seg_s2    <= seg_s1;
            cs_s1     <= CS_N;
            cs_s2     <= cs_s1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Window classification on the synchronized selects
    // ------------------------------------------------------------------
    logic       win_idle;
    logic       win_single;
    logic       win_multi;
    logic [1:0] win_idx;

    always_comb begin
        win_idle   = (cs_s2 == 4'hF);
        win_single = 1'b0;
        win_idx    = 2'd0;
        case (cs_s2)
            4'b1110: begin win_single = 1'b1; win_idx = 2'd0; end
            4'b1101: begin win_single = 1'b1; win_idx = 2'd1; end
            4'b1011: begin win_single = 1'b1; win_idx = 2'd2; end
            4'b0111: begin win_single = 1'b1; win_idx = 2'd3; end
            default: ;
        endcase
        win_multi = !win_idle && !win_single;
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t     state;
    logic [1:0] cur_idx;
    logic [7:0] prev_seg;
    logic [7:0] stab_cnt;
    logic       cs_err;
    // Set once a genuine all-high select has been seen after reset, so a
    // window already in progress at reset release is never captured.
    logic       armed;

    logic       cap_hit;

    assign cap_hit = (state == TRACK) && win_single && (win_idx == cur_idx)
                     && (seg_s2 == prev_seg) && (stab_cnt == CAP_AT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            cur_idx  <= 2'd0;
            prev_seg <= 8'hFF;
            stab_cnt <= 8'd0;
            cs_err   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            // A multi-select in the same cycle as CLR_ERR keeps the flag set.
            if (win_multi) begin
                cs_err <= 1'b1;
            end else if (CLR_ERR) begin
                cs_err <= 1'b0;
            end

            if (sync_fill[1] && win_idle) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (win_multi) begin
                        state    <= ERR;
                        stab_cnt <= 8'd0;
                    end else if (win_single && armed) begin
                        state    <= TRACK;
                        cur_idx  <= win_idx;
                        prev_seg <= seg_s2;
                        stab_cnt <= 8'd1;
                    end
                end

                TRACK: begin
                    if (win_multi) begin
                        state    <= ERR;
                        stab_cnt <= 8'd0;
                    end else if (win_idle) begin
                        state    <= IDLE;
                        stab_cnt <= 8'd0;
                    end else if (win_idx != cur_idx) begin
                        cur_idx  <= win_idx;
                        prev_seg <= seg_s2;
                        stab_cnt <= 8'd1;
                    end else if (cap_hit) begin
                        state    <= HOLD;
                        stab_cnt <= 8'd0;
                    end else if (seg_s2 == prev_seg) begin
                        stab_cnt <= stab_cnt + 8'd1;
                    end else begin
                        prev_seg <= seg_s2;
                        stab_cnt <= 8'd1;
                    end
                end

                HOLD: begin
                    // Segment changes inside an already captured window are ignored.
                    if (win_multi) begin
                        state    <= ERR;
                        stab_cnt <= 8'd0;
                    end else if (win_idle) begin
                        state    <= IDLE;
                    end else if (win_idx != cur_idx) begin
                        state    <= TRACK;
                        cur_idx  <= win_idx;
                        prev_seg <= seg_s2;
                        stab_cnt <= 8'd1;
                    end
                end

                ERR: begin
                    stab_cnt <= 8'd0;
                    if (win_idle) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    stab_cnt <= 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit registers and frame tracking
    // ------------------------------------------------------------------
    logic [7:0] dig_q [4];
    logic [3:0] seen;
    logic [3:0] seen_nxt;
    logic       frame_stb;

    // Recapturing a digit already in 'seen' leaves the set unchanged.
    assign seen_nxt = seen | (4'b0001 << cur_idx);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 4; k++) begin
                dig_q[k] <= 8'hFF;
            end
            seen      <= 4'h0;
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            if (cap_hit) begin
                dig_q[cur_idx] <= seg_s2;
                if (seen_nxt == 4'hF) begin
                    seen      <= 4'h0;
                    frame_stb <= 1'b1;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-digit refresh timeout
    // ------------------------------------------------------------------
    logic [TO_W-1:0] age_q [4];
    logic [3:0]      dig_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 4; k++) begin
                age_q[k] <= '0;
            end
            dig_valid <= 4'h0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (cap_hit && (cur_idx == 2'(k))) begin
                    age_q[k]     <= '0;
                    dig_valid[k] <= 1'b1;
                end else if (age_q[k] != AGE_MAX) begin
                    age_q[k] <= age_q[k] + AGE_ONE;
                    // Valid drops on the edge where the age reaches all-ones.
                    if (age_q[k] == AGE_MAX - AGE_ONE) begin
                        dig_valid[k] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hex decode (DP ignored)
    // ------------------------------------------------------------------
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [4:0] dec;

    always_comb begin
        HEX_NIB = 16'h0000;
        HEX_OK  = 4'h0;
        dec     = 5'h00;
        for (int k = 0; k < 4; k++) begin
            dec              = seg_decode(dig_q[k][6:0]);
            HEX_NIB[4*k +: 4] = dec[3:0];
            HEX_OK[k]        = dec[4];
        end
    end

    assign DIG0      = dig_q[0];
    assign DIG1      = dig_q[1];
    assign DIG2      = dig_q[2];
    assign DIG3      = dig_q[3];
    assign DIG_VALID = dig_valid;
    assign FRAME_STB = frame_stb;
    assign CS_ERR    = cs_err;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Purpose: self-checking bench for seg7_scan_capture with directed scenarios and randomized scanning.
// Latency: reference model sees pins two edges late, mirroring the input synchronizers.
// Backpressure: none; stimulus is driven on the falling edge, outputs sampled on the falling edge.
module tb_seg7_scan_capture;

    localparam int N       = 8;
    localparam int TW      = 6;
    localparam int AGE_LIM = (1 << TW) - 1;

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [3:0] MULTI [7] = '{4'b1100, 4'b1010, 4'b0110, 4'b1001, 4'b0101, 4'b0011, 4'b0000};

    logic        CLK     = 1'b0;
    logic        RST_N   = 1'b0;
    logic [7:0]  SEG_IN  = 8'hFF;
    logic [3:0]  CS_N    = 4'hF;
    logic        CLR_ERR = 1'b0;
    logic [7:0]  DIG0, DIG1, DIG2, DIG3;
    logic [3:0]  DIG_VALID;
    logic [15:0] HEX_NIB;
    logic [3:0]  HEX_OK;
    logic        FRAME_STB;
    logic        CS_ERR;

    int n_pass  = 0;
    int n_total = 0;

    seg7_scan_capture #(.STABLE_CNT(N), .TO_W(TW)) dut (
        .RST_N     (RST_N),
        .CLK       (CLK),
        .SEG_IN    (SEG_IN),
        .CS_N      (CS_N),
        .CLR_ERR   (CLR_ERR),
        .DIG0      (DIG0),
        .DIG1      (DIG1),
        .DIG2      (DIG2),
        .DIG3      (DIG3),
        .DIG_VALID (DIG_VALID),
        .HEX_NIB   (HEX_NIB),
        .HEX_OK    (HEX_OK),
        .FRAME_STB (FRAME_STB),
        .CS_ERR    (CS_ERR)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: a capture happens when, since the last genuine idle,
    // the current single-digit window holds N equal samples in a row and has
    // not captured yet. Pins reach the decision two edges after sampling.
    // ------------------------------------------------------------------
    logic [7:0]  m_dig [4];
    bit          m_has [4];
    int          m_cap_edge [4];
    logic [3:0]  m_seen;
    bit          m_stb, m_err, m_clean, m_done;
    int          m_win, m_edge;
    logic [11:0] m_pins [$];
    logic [7:0]  m_hseg [$];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_dig[k] = 8'hFF; m_has[k] = 0; m_cap_edge[k] = 0;
        end
        m_seen = 4'h0; m_stb = 0; m_err = 0; m_clean = 0; m_done = 0;
        m_win = -1; m_edge = 0;
        m_pins.delete(); m_hseg.delete();
    endtask

    task automatic model_step();
        logic [11:0] smp;
        logic [3:0]  cs;
        logic [7:0]  seg;
        int          nlow, k;
        bit          eq;
        m_edge++;
        m_stb = 0;
        m_pins.push_back({CS_N, SEG_IN});
        if (m_pins.size() < 3) begin
            if (CLR_ERR) m_err = 0;
            return;
        end
        smp = m_pins.pop_front();
        cs = smp[11:8];
        seg = smp[7:0];
        nlow = 0; k = 0;
        for (int i = 0; i < 4; i++) if (!cs[i]) begin nlow++; k = i; end
        if (nlow >= 2) begin m_err = 1; m_clean = 0; m_win = -1; return; end
        if (CLR_ERR) m_err = 0;
        if (nlow == 0) begin m_clean = 1; m_win = -1; return; end
        if (!m_clean) return;
        if (k != m_win) begin m_win = k; m_hseg.delete(); m_done = 0; end
        if (m_done) return;
        m_hseg.push_back(seg);
        if (m_hseg.size() < N) return;
        eq = 1;
        for (int i = m_hseg.size() - N; i < m_hseg.size(); i++) if (m_hseg[i] !== seg) eq = 0;
        if (!eq) return;
        m_done = 1;
        m_dig[k] = seg; m_has[k] = 1; m_cap_edge[k] = m_edge;
        m_seen[k] = 1'b1;
        if (m_seen == 4'hF) begin m_stb = 1; m_seen = 4'h0; end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_reset();
        else model_step();
    end

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_has[k] && ((m_edge - m_cap_edge[k]) < AGE_LIM);
        return v;
    endfunction

    function automatic logic [19:0] exp_hex();
        logic [19:0] r;
        r = 20'h0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 16; i++)
                if (m_dig[k][6:0] == GLYPH[i]) begin
                    r[16 + k] = 1'b1;
                    r[4*k +: 4] = 4'(i);
                end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 0; CS_N = 4'hF; SEG_IN = 8'hFF; CLR_ERR = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1;
        repeat (4) @(negedge CLK);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        RST_N = 0;
        repeat (3) @(negedge CLK);
        n_total++; if ({DIG3, DIG2, DIG1, DIG0} !== 32'hFFFF_FFFF) $display("FAIL reset_dig: got %h expected ffffffff", {DIG3, DIG2, DIG1, DIG0}); else n_pass++;
        n_total++; if (DIG_VALID !== 4'h0) $display("FAIL reset_valid: got %b expected 0000", DIG_VALID); else n_pass++;
        n_total++; if (HEX_NIB !== 16'h0) $display("FAIL reset_hex_nib: got %h expected 0000", HEX_NIB); else n_pass++;
        n_total++; if (HEX_OK !== 4'h0) $display("FAIL reset_hex_ok: got %b expected 0000", HEX_OK); else n_pass++;
        n_total++; if (FRAME_STB !== 1'b0) $display("FAIL reset_frame_stb: got %b expected 0", FRAME_STB); else n_pass++;
        n_total++; if (CS_ERR !== 1'b0) $display("FAIL reset_cs_err: got %b expected 0", CS_ERR); else n_pass++;
        RST_N = 1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_single_capture();
        CS_N = 4'b1110; SEG_IN = 8'hC0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge CLK);
            if (e == 9) begin
                n_total++; if (DIG0 !== 8'hFF) $display("FAIL single_early: DIG0 got %h expected ff at edge 9", DIG0); else n_pass++;
            end
            if (e == 10) begin
                n_total++; if (DIG0 !== 8'hC0) $display("FAIL single_dig0: got %h expected c0 at edge 10", DIG0); else n_pass++;
                n_total++; if (DIG_VALID !== 4'b0001) $display("FAIL single_valid: got %b expected 0001", DIG_VALID); else n_pass++;
                n_total++; if (HEX_NIB[3:0] !== 4'h0 || HEX_OK[0] !== 1'b1) $display("FAIL single_hex: got nib %h ok %b expected 0/1", HEX_NIB[3:0], HEX_OK[0]); else n_pass++;
            end
        end
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_frame_scan();
        logic [7:0] codes [4];
        int pulses;
        codes[0] = 8'hC0; codes[1] = 8'hF9; codes[2] = 8'hA4; codes[3] = 8'hB0;
        pulses = 0;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 20; c++) begin
                if (c < 16) begin CS_N = ~(4'b0001 << d); SEG_IN = codes[d]; end
                else CS_N = 4'hF;
                @(negedge CLK);
                if (FRAME_STB) begin
                    pulses++;
                    n_total++; if (DIG3 !== 8'hB0) $display("FAIL frame_coincident: DIG3 got %h expected b0 with FRAME_STB", DIG3); else n_pass++;
                end
            end
        end
        repeat (4) begin @(negedge CLK); if (FRAME_STB) pulses++; end
        n_total++; if (pulses != 1) $display("FAIL frame_pulses: got %0d expected 1", pulses); else n_pass++;
        n_total++; if (HEX_NIB !== 16'h3210) $display("FAIL frame_hex_nib: got %h expected 3210", HEX_NIB); else n_pass++;
        n_total++; if (HEX_OK !== 4'hF) $display("FAIL frame_hex_ok: got %b expected 1111", HEX_OK); else n_pass++;
    endtask

    task automatic test_unstable();
        do_reset();
        CS_N = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            SEG_IN = ((c / 5) % 2 == 0) ? 8'hC0 : 8'hF9;
            @(negedge CLK);
        end
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
        n_total++; if (DIG1 !== 8'hFF) $display("FAIL unstable_dig1: got %h expected ff", DIG1); else n_pass++;
        n_total++; if (DIG_VALID !== 4'h0) $display("FAIL unstable_valid: got %b expected 0000", DIG_VALID); else n_pass++;
        CS_N = 4'b1101; SEG_IN = 8'h92;
        repeat (16) @(negedge CLK);
        n_total++; if (DIG1 !== 8'h92) $display("FAIL steady_dig1: got %h expected 92", DIG1); else n_pass++;
        n_total++; if (HEX_NIB[7:4] !== 4'h5 || HEX_OK[1] !== 1'b1) $display("FAIL steady_hex: got nib %h ok %b expected 5/1", HEX_NIB[7:4], HEX_OK[1]); else n_pass++;
        n_total++; if (DIG_VALID[1] !== 1'b1) $display("FAIL steady_valid: got %b expected 1", DIG_VALID[1]); else n_pass++;
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_cs_err();
        do_reset();
        CS_N = 4'b1100; SEG_IN = 8'hC0;
        repeat (3) @(negedge CLK);
        CS_N = 4'hF;
        repeat (3) @(negedge CLK);
        n_total++; if (CS_ERR !== 1'b1) $display("FAIL err_set: got %b expected 1", CS_ERR); else n_pass++;
        n_total++; if ({DIG1, DIG0} !== 16'hFFFF || DIG_VALID !== 4'h0) $display("FAIL err_nocap: got dig %h valid %b expected ffff/0000", {DIG1, DIG0}, DIG_VALID); else n_pass++;
        CLR_ERR = 1;
        @(negedge CLK);
        CLR_ERR = 0;
        n_total++; if (CS_ERR !== 1'b0) $display("FAIL err_clear: got %b expected 0", CS_ERR); else n_pass++;
        CS_N = 4'b1100;
        repeat (3) @(negedge CLK);
        CLR_ERR = 1;
        @(negedge CLK);
        CLR_ERR = 0;
        n_total++; if (CS_ERR !== 1'b1) $display("FAIL err_clr_vs_multi: got %b expected 1", CS_ERR); else n_pass++;
        // Multi-select straight into a single select: no capture without an idle gap.
        CS_N = 4'b1110;
        repeat (16) @(negedge CLK);
        n_total++; if (DIG0 !== 8'hFF) $display("FAIL err_no_idle_cap: DIG0 got %h expected ff", DIG0); else n_pass++;
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
        n_total++; if (CS_ERR !== 1'b1) $display("FAIL err_sticky: got %b expected 1", CS_ERR); else n_pass++;
    endtask

    task automatic test_timeout();
        bit found;
        do_reset();
        CS_N = 4'b1011; SEG_IN = 8'hA4;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (DIG_VALID[2]) found = 1;
        end
        n_total++; if (!found) $display("FAIL timeout_capture: DIG_VALID[2] got 0 expected 1 within 20 cycles"); else n_pass++;
        CS_N = 4'hF;
        for (int j = 1; j <= AGE_LIM; j++) begin
            @(negedge CLK);
            if (j == AGE_LIM - 1) begin
                n_total++; if (DIG_VALID[2] !== 1'b1) $display("FAIL timeout_before: got %b expected 1 at %0d cycles", DIG_VALID[2], j); else n_pass++;
            end
            if (j == AGE_LIM) begin
                n_total++; if (DIG_VALID[2] !== 1'b0) $display("FAIL timeout_drop: got %b expected 0 at %0d cycles", DIG_VALID[2], j); else n_pass++;
                n_total++; if (DIG2 !== 8'hA4 || HEX_NIB[11:8] !== 4'h2) $display("FAIL timeout_retain: got %h nib %h expected a4/2", DIG2, HEX_NIB[11:8]); else n_pass++;
            end
        end
        CS_N = 4'b1011; SEG_IN = 8'hFF;
        repeat (14) @(negedge CLK);
        CS_N = 4'hF;
        n_total++; if (DIG2 !== 8'hFF || DIG_VALID[2] !== 1'b1) $display("FAIL blank_capture: got %h valid %b expected ff/1", DIG2, DIG_VALID[2]); else n_pass++;
        n_total++; if (HEX_OK[2] !== 1'b0 || HEX_NIB[11:8] !== 4'h0) $display("FAIL blank_decode: got ok %b nib %h expected 0/0", HEX_OK[2], HEX_NIB[11:8]); else n_pass++;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        CS_N = 4'b1101; SEG_IN = 8'hF9;
        repeat (14) @(negedge CLK);
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
        CS_N = 4'b1110; SEG_IN = 8'hC0;
        repeat (5) @(negedge CLK);
        #2 RST_N = 0;
        #1;
        n_total++; if ({DIG3, DIG2, DIG1, DIG0} !== 32'hFFFF_FFFF || DIG_VALID !== 4'h0) $display("FAIL midrst_dig: got %h valid %b expected ffffffff/0000", {DIG3, DIG2, DIG1, DIG0}, DIG_VALID); else n_pass++;
        n_total++; if (HEX_NIB !== 16'h0 || HEX_OK !== 4'h0 || FRAME_STB !== 1'b0 || CS_ERR !== 1'b0) $display("FAIL midrst_misc: got nib %h ok %b stb %b err %b expected all 0", HEX_NIB, HEX_OK, FRAME_STB, CS_ERR); else n_pass++;
        repeat (2) @(negedge CLK);
        RST_N = 1;
        repeat (20) @(negedge CLK);
        n_total++; if (DIG0 !== 8'hFF || DIG_VALID[0] !== 1'b0) $display("FAIL midrst_nocap: got %h valid %b expected ff/0", DIG0, DIG_VALID[0]); else n_pass++;
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
        CS_N = 4'b1110;
        repeat (14) @(negedge CLK);
        n_total++; if (DIG0 !== 8'hC0) $display("FAIL midrst_fresh: got %h expected c0", DIG0); else n_pass++;
        CS_N = 4'hF;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_random();
        int len, gap, tog_at;
        logic [3:0] cs;
        logic [7:0] sa, sb;
        logic [19:0] eh;
        do_reset();
        for (int w = 0; w < 40; w++) begin
            if ($urandom_range(0, 9) == 0) cs = MULTI[$urandom_range(0, 6)];
            else cs = ~(4'b0001 << $urandom_range(0, 3));
            sa = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {1'($urandom), GLYPH[$urandom_range(0, 15)]};
            sb = {1'($urandom), GLYPH[$urandom_range(0, 15)]};
            len = $urandom_range(3, 20);
            gap = $urandom_range(0, 4);
            tog_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : len + 100;
            for (int c = 0; c < len + gap; c++) begin
                if (c < len) begin CS_N = cs; SEG_IN = (c >= tog_at) ? sb : sa; end
                else begin CS_N = 4'hF; SEG_IN = 8'($urandom); end
                CLR_ERR = ($urandom_range(0, 11) == 0);
                @(negedge CLK);
                eh = exp_hex();
                n_total++; if ({DIG3, DIG2, DIG1, DIG0} !== {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}) $display("FAIL rand_dig: got %h expected %h", {DIG3, DIG2, DIG1, DIG0}, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}); else n_pass++;
                n_total++; if (DIG_VALID !== exp_valid()) $display("FAIL rand_valid: got %b expected %b", DIG_VALID, exp_valid()); else n_pass++;
                n_total++; if (HEX_NIB !== eh[15:0]) $display("FAIL rand_hex_nib: got %h expected %h", HEX_NIB, eh[15:0]); else n_pass++;
                n_total++; if (HEX_OK !== eh[19:16]) $display("FAIL rand_hex_ok: got %b expected %b", HEX_OK, eh[19:16]); else n_pass++;
                n_total++; if (FRAME_STB !== m_stb) $display("FAIL rand_frame_stb: got %b expected %b", FRAME_STB, m_stb); else n_pass++;
                n_total++; if (CS_ERR !== m_err) $display("FAIL rand_cs_err: got %b expected %b", CS_ERR, m_err); else n_pass++;
            end
        end
        CLR_ERR = 0;
        CS_N = 4'hF;
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_frame_scan();
        test_unstable();
        test_cs_err();
        test_timeout();
        test_reset_mid_window();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 8: number of consecutive identical synchronized segment samples needed to capture a digit (range 2..255).
REQ-002 SHALL have parameter TO_W, default 20: width of each per-digit refresh-timeout counter.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 CLK  in  1  system clock; all logic rising-edge.
REQ-005 SEG_IN  in  8  multiplexed segment bus, active-low; bit0=A .. bit6=G, bit7=DP.
REQ-006 CS_N  in  4  digit selects, active-low; bit k selects digit k.
REQ-007 CLR_ERR  in  1  synchronous pulse; clears CS_ERR.
REQ-008 DIG0..DIG3  out  8 each  last captured raw segment code per digit.
REQ-009 DIG_VALID  out  4  bit k set while DIGk holds a fresh capture.
REQ-010 HEX_NIB  out  16  decoded nibble per digit; [4k+3:4k] = digit k.
REQ-011 HEX_OK  out  4  bit k set when DIGk[6:0] matches a hex glyph.
REQ-012 FRAME_STB  out  1  one-cycle pulse when all four digits have been captured since the last pulse.
REQ-013 CS_ERR  out  1  sticky flag: more than one CS_N bit low at once.

Function
REQ-014 SEG_IN and CS_N SHALL pass through 2-flop synchronizers, reset to 8'hFF and 4'hF; all decisions use synchronized values.
REQ-015 Window: exactly one synced CS_N bit low means digit k active; all high means idle; two or more low means multi-select.
REQ-016 FSM states: IDLE, TRACK, HOLD, ERR; reset state IDLE.
REQ-017 IDLE->TRACK on window start; stability count loaded to 1, digit index latched.
REQ-018 TRACK: same digit and synced SEG equal to previous sample -> count+1; SEG change -> count reloads to 1, stay TRACK.
REQ-019 TRACK: on the STABLE_CNT-th consecutive equal sample, DIGk <= sample, DIG_VALID[k] <= 1, seen[k] <= 1, age[k] <= 0, go HOLD; all registered together.
REQ-020 HOLD: no further capture until window ends; SEG changes ignored.
REQ-021 TRACK/HOLD -> IDLE when all CS_N high; active digit changes directly to another single digit -> TRACK with count 1 for the new digit.
REQ-022 Any state -> ERR on multi-select; CS_ERR <= 1; no capture; count cleared; ERR -> IDLE only when all CS_N high.
REQ-023 CLR_ERR clears CS_ERR next edge; a new multi-select in the same cycle wins (CS_ERR stays 1).
REQ-024 FRAME_STB SHALL assert in the same cycle a capture makes seen == 4'hF; seen clears to 4'h0 on that edge; at most one pulse per capture.
REQ-025 Recapturing an already-seen digit SHALL update DIGk but not advance seen.
REQ-026 Per-digit age counter, TO_W bits, increments each cycle, saturates at all-ones; at saturation DIG_VALID[k] <= 0, DIGk retained; capture of k clears age[k].
REQ-027 Decode on DIGk[6:0], DP ignored: 40=0,79=1,24=2,30=3,19=4,12=5,02=6,78=7,00=8,10=9,08=A,03=b,46=C,21=d,06=E,0E=F; no match -> nibble 0, HEX_OK[k]=0; HEX_NIB/HEX_OK combinational from DIGk.
REQ-028 Latency: pins stable from sampling edge 1 -> DIGk updated at edge STABLE_CNT+2.

Reset
REQ-029 On RST_N low, asynchronously: DIG0..3=8'hFF, DIG_VALID=0, seen=0, ages=0, counts=0, FRAME_STB=0, CS_ERR=0, FSM IDLE; HEX_OK=0, HEX_NIB=0 as consequence.
REQ-030 Reset mid-window SHALL discard the partial capture; after release, the first capture requires a fresh window start (CS_N all high then one low).

Verification
REQ-031 CS_N=1110, SEG_IN=C0 held 20 cycles -> DIG0=C0 at edge 10, DIG_VALID=0001, HEX_NIB[3:0]=0, HEX_OK[0]=1.
REQ-032 Scan digits 0..3 with C0,F9,A4,B0, 16-cycle windows, 4 idle cycles between -> FRAME_STB exactly one pulse, coincident with DIG3=B0; HEX_NIB=16'h3210.
REQ-033 Window with SEG toggling C0/F9 every 5 cycles -> no capture, DIG_VALID unchanged; second window steady 8'h92 -> DIG updated, HEX nibble 5.
REQ-034 CS_N=1100 for 3 cycles -> CS_ERR=1, no capture; CLR_ERR pulsed with CS_N=1111 -> CS_ERR=0 next edge; CLR_ERR coincident with multi-select -> CS_ERR stays 1.
REQ-035 TO_W=6, capture digit 2 then stop scanning -> DIG_VALID[2] drops at 63 cycles after capture, DIG2 unchanged; SEG 8'hFF captured -> HEX_OK=0.
REQ-036 RST_N low at cycle 5 of a 16-cycle window -> all outputs at reset values; window continuing after release -> no capture until CS_N returns to 1111.
